// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared types and width helpers for the banked RAM slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

  // Which side wins the next same-bank conflict in single-port mode.
  typedef enum logic [0:0] {
    WR_PRIO = 1'b0,
    RD_PRIO = 1'b1
  } prio_e;

  // Row index width inside one bank.
  function automatic int calc_row_w(input int words);
    return $clog2(words);
  endfunction

  // Bank select width; a single bank needs no select bits.
  function automatic int calc_bank_w(input int num_bank);
    return (num_bank > 1) ? $clog2(num_bank) : 0;
  endfunction

  // Full word address width: row bits above the low-order bank bits.
  function automatic int calc_addr_w(input int words, input int num_bank);
    return calc_row_w(words) + calc_bank_w(num_bank);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_banked_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_banked_arb_if
//  Description : Write/read request bus of the banked RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_banked_arb_if
  import ram_pkg::*;
#(
  parameter int ADDR_W     = calc_addr_w(64, 4),
  parameter int SRAM_WIDTH = 256,
  parameter int SRAM_BYTE  = 32
);
  logic                  wr_val;
  logic                  wr_rdy;
  logic [ADDR_W-1:0]     wr_addr;
  logic [SRAM_WIDTH-1:0] wr_data;
  logic [SRAM_BYTE-1:0]  wr_mask;
  logic                  rd_val;
  logic                  rd_rdy;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_data_val;
  logic [SRAM_WIDTH-1:0] rd_data;

  modport master (
    output wr_val, wr_addr, wr_data, wr_mask, rd_val, rd_addr,
    input  wr_rdy, rd_rdy, rd_data_val, rd_data
  );

  modport slave (
    input  wr_val, wr_addr, wr_data, wr_mask, rd_val, rd_addr,
    output wr_rdy, rd_rdy, rd_data_val, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/ram_bank_mask.sv
`default_nettype none
// ============================================================================
//  Module      : ram_bank_mask
//  Description : One behavioural RAM bank, byte-masked write, registered
//                read-first read. Technology macros replace this body.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_bank_mask
  import ram_pkg::*;
#(
  parameter int SRAM_BIT  = 8,
  parameter int SRAM_BYTE = 32,
  parameter int SRAM_WORD = 64,
  parameter int DUAL_PORT = 0,
  parameter int ROW_W     = calc_row_w(SRAM_WORD)
) (
  input  wire logic                            clk,
  input  wire logic                            wr_en,
  input  wire logic [ROW_W-1:0]                wr_row,
  input  wire logic [SRAM_BIT*SRAM_BYTE-1:0]   wr_data,
  input  wire logic [SRAM_BYTE-1:0]            wr_mask,
  input  wire logic                            rd_en,
  input  wire logic [ROW_W-1:0]                rd_row,
  output logic      [SRAM_BIT*SRAM_BYTE-1:0]   rd_data
);

  logic [SRAM_BIT*SRAM_BYTE-1:0] mem [SRAM_WORD];
  logic                          w_rd_go;

  // A single-port macro cannot read while it writes; the top-level arbiter
  // never asks it to, so this only mirrors the physical port.
  assign w_rd_go = rd_en & ((DUAL_PORT != 0) | ~wr_en);

  // Byte-lane masked write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < SRAM_BYTE; i++) begin
        if (wr_mask[i]) begin
          mem[wr_row][i*SRAM_BIT +: SRAM_BIT] <= wr_data[i*SRAM_BIT +: SRAM_BIT];
        end
      end
    end
  end

  // Registered read; sees the pre-write word on a same-row collision.
  always_ff @(posedge clk) begin
    if (w_rd_go) begin
      rd_data <= mem[rd_row];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_banked_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ram_banked_arb
//  Description : Low-order interleaved multi-bank RAM with one write and one
//                read port, fair same-bank arbitration in single-port mode,
//                optional write-to-read bypass in dual-port mode, and a held
//                read output.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_banked_arb
  import ram_pkg::*;
#(
  parameter int SRAM_BIT  = 8,
  parameter int SRAM_BYTE = 32,
  parameter int SRAM_WORD = 64,
  parameter int NUM_BANK  = 4,
  parameter int DUAL_PORT = 0,
  parameter int BYPASS    = 0
) (
  input  wire logic         clk,
  input  wire logic         rst,
  ram_banked_arb_if.slave   bus
);

  localparam int  SRAM_WIDTH = SRAM_BIT * SRAM_BYTE;
  localparam int  ROW_W      = calc_row_w(SRAM_WORD);
  localparam int  BANK_W     = calc_bank_w(NUM_BANK);
  localparam int  ADDR_W     = calc_addr_w(SRAM_WORD, NUM_BANK);
  localparam int  BANK_IW    = (BANK_W > 0) ? BANK_W : 1;
  localparam bit  USE_BYPASS = (DUAL_PORT != 0) && (BYPASS != 0);

  logic [BANK_IW-1:0]    w_wr_bank;
  logic [BANK_IW-1:0]    w_rd_bank;
  logic [ROW_W-1:0]      w_wr_row;
  logic [ROW_W-1:0]      w_rd_row;
  logic                  w_conflict;
  logic                  w_wr_rdy;
  logic                  w_rd_rdy;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  prio_e                 r_prio;
  logic                  r_rd_data_val;
  logic [BANK_IW-1:0]    r_rd_bank;
  logic [SRAM_WIDTH-1:0] r_hold;
  logic [SRAM_WIDTH-1:0] w_bank_rd_data [NUM_BANK];
  logic [SRAM_WIDTH-1:0] w_bank_out;
  logic [SRAM_WIDTH-1:0] w_merged;

  // Address split: bank in the low bits, row above.
  assign w_wr_row = bus.wr_addr[ADDR_W-1:BANK_W];
  assign w_rd_row = bus.rd_addr[ADDR_W-1:BANK_W];

  generate
    if (BANK_W > 0) begin : g_bank_decode
      assign w_wr_bank = bus.wr_addr[BANK_W-1:0];
      assign w_rd_bank = bus.rd_addr[BANK_W-1:0];
    end else begin : g_single_bank
      assign w_wr_bank = '0;
      assign w_rd_bank = '0;
    end
  endgenerate

  // Conflict detection and handshake; the loser of a conflict sees rdy=0.
  always_comb begin
    w_conflict = (DUAL_PORT == 0) && bus.wr_val && bus.rd_val && (w_wr_bank == w_rd_bank);
    w_wr_rdy   = ~rst & (~w_conflict | (r_prio == WR_PRIO));
    w_rd_rdy   = ~rst & (~w_conflict | (r_prio == RD_PRIO));
    w_wr_acc   = bus.wr_val & w_wr_rdy;
    w_rd_acc   = bus.rd_val & w_rd_rdy;
  end

  assign bus.wr_rdy = w_wr_rdy;
  assign bus.rd_rdy = w_rd_rdy;

  // Priority toggles only when a conflict was actually resolved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= WR_PRIO;
    end else if (w_conflict) begin
      r_prio <= (r_prio == WR_PRIO) ? RD_PRIO : WR_PRIO;
    end
  end

  generate
    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
      logic w_bank_wr_en;
      logic w_bank_rd_en;

      assign w_bank_wr_en = w_wr_acc && (w_wr_bank == BANK_IW'(b));
      assign w_bank_rd_en = w_rd_acc && (w_rd_bank == BANK_IW'(b));

      ram_bank_mask #(
        .SRAM_BIT  (SRAM_BIT),
        .SRAM_BYTE (SRAM_BYTE),
        .SRAM_WORD (SRAM_WORD),
        .DUAL_PORT (DUAL_PORT),
        .ROW_W     (ROW_W)
      ) u_bank (
        .clk     (clk),
        .wr_en   (w_bank_wr_en),
        .wr_row  (w_wr_row),
        .wr_data (bus.wr_data),
        .wr_mask (bus.wr_mask),
        .rd_en   (w_bank_rd_en),
        .rd_row  (w_rd_row),
        .rd_data (w_bank_rd_data[b])
      );
    end
  endgenerate

  // Read-valid delay and the bank that will present the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data_val <= 1'b0;
      r_rd_bank     <= '0;
    end else begin
      r_rd_data_val <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_bank <= w_rd_bank;
      end
    end
  end

  assign w_bank_out = w_bank_rd_data[r_rd_bank];

  generate
    if (USE_BYPASS) begin : g_bypass
      logic                  r_byp_hit;
      logic [SRAM_WIDTH-1:0] r_byp_data;
      logic [SRAM_BYTE-1:0]  r_byp_mask;

      // Remember a same-address write so its lanes override the stale read.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_byp_hit  <= 1'b0;
          r_byp_data <= '0;
          r_byp_mask <= '0;
        end else if (w_rd_acc) begin
          r_byp_hit  <= w_wr_acc && (bus.wr_addr == bus.rd_addr);
          r_byp_data <= bus.wr_data;
          r_byp_mask <= bus.wr_mask;
        end
      end

      // Per-lane merge of bypassed write data over the bank output.
      always_comb begin
        w_merged = w_bank_out;
        if (r_byp_hit) begin
          for (int i = 0; i < SRAM_BYTE; i++) begin
            if (r_byp_mask[i]) begin
              w_merged[i*SRAM_BIT +: SRAM_BIT] = r_byp_data[i*SRAM_BIT +: SRAM_BIT];
            end
          end
        end
      end
    end else begin : g_no_bypass
      assign w_merged = w_bank_out;
    end
  endgenerate

  // Hold the most recent read so rd_data stays stable between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (r_rd_data_val) begin
      r_hold <= w_merged;
    end
  end

  assign bus.rd_data_val = r_rd_data_val;
  assign bus.rd_data     = r_rd_data_val ? w_merged : r_hold;

endmodule
`default_nettype wire

// File: tb/tb_ram_banked_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_banked_arb
//  Description : Self-checking bench for ram_banked_arb. Three instances:
//                single-port, dual-port read-first, dual-port bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_banked_arb;

  localparam int AW = 8;
  localparam int W  = 256;
  localparam int NB = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Per-instance stimulus and observed outputs (0: SP, 1: DP, 2: DP+bypass)
  logic          t_wv [3];
  logic [AW-1:0] t_wa [3];
  logic [W-1:0]  t_wd [3];
  logic [NB-1:0] t_wm [3];
  logic          t_rv [3];
  logic [AW-1:0] t_ra [3];
  logic          o_wrdy [3];
  logic          o_rrdy [3];
  logic          o_rdv  [3];
  logic [W-1:0]  o_rdat [3];

  ram_banked_arb_if #(.ADDR_W(AW), .SRAM_WIDTH(W), .SRAM_BYTE(NB)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_conn
    assign bus[g].wr_val  = t_wv[g];
    assign bus[g].wr_addr = t_wa[g];
    assign bus[g].wr_data = t_wd[g];
    assign bus[g].wr_mask = t_wm[g];
    assign bus[g].rd_val  = t_rv[g];
    assign bus[g].rd_addr = t_ra[g];
    assign o_wrdy[g] = bus[g].wr_rdy;
    assign o_rrdy[g] = bus[g].rd_rdy;
    assign o_rdv[g]  = bus[g].rd_data_val;
    assign o_rdat[g] = bus[g].rd_data;
  end

  ram_banked_arb #(.NUM_BANK(4), .DUAL_PORT(0), .BYPASS(0)) dut_sp (.clk(clk), .rst(rst), .bus(bus[0]));
  ram_banked_arb #(.NUM_BANK(4), .DUAL_PORT(1), .BYPASS(0)) dut_dp (.clk(clk), .rst(rst), .bus(bus[1]));
  ram_banked_arb #(.NUM_BANK(4), .DUAL_PORT(1), .BYPASS(1)) dut_by (.clk(clk), .rst(rst), .bus(bus[2]));

  // Reference model: plain word arrays, who-goes-next bit, last read value
  logic [W-1:0] m_mem [3][256];
  logic         m_rd_turn;
  logic         m_rdv  [3];
  logic [W-1:0] m_last [3];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] pat_a5, pat_aa, pat_55, pat_ones;

  task automatic model_reset();
    m_rd_turn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      m_rdv[d]  = 1'b0;
      m_last[d] = '0;
    end
  endtask

  task automatic apply_reset();
    for (int d = 0; d < 3; d++) begin
      t_wv[d] = 1'b0;
      t_rv[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus on instance d; other instances are idled.
  task automatic drive_cycle(input int d, input logic w_v, input logic [AW-1:0] w_a,
                             input logic [W-1:0] w_d, input logic [NB-1:0] w_m,
                             input logic r_v, input logic [AW-1:0] r_a,
                             output logic got_w, output logic got_r,
                             output logic exp_w, output logic exp_r);
    logic         conflict;
    logic [W-1:0] rval;
    for (int k = 0; k < 3; k++) begin
      if (k != d) begin
        t_wv[k] = 1'b0;
        t_rv[k] = 1'b0;
      end
    end
    t_wv[d] = w_v; t_wa[d] = w_a; t_wd[d] = w_d; t_wm[d] = w_m;
    t_rv[d] = r_v; t_ra[d] = r_a;
    #1;
    got_w = o_wrdy[d];
    got_r = o_rrdy[d];
    conflict = (d == 0) && w_v && r_v && ((w_a % 4) == (r_a % 4));
    exp_w = !conflict || !m_rd_turn;
    exp_r = !conflict || m_rd_turn;
    if (conflict) m_rd_turn = !m_rd_turn;
    rval = '0;
    if (r_v && exp_r) begin
      rval = m_mem[d][r_a];
      if (d == 2 && w_v && exp_w && w_a == r_a) begin
        for (int i = 0; i < NB; i++)
          if (w_m[i]) rval[8*i +: 8] = w_d[8*i +: 8];
      end
    end
    if (w_v && exp_w) begin
      for (int i = 0; i < NB; i++)
        if (w_m[i]) m_mem[d][w_a][8*i +: 8] = w_d[8*i +: 8];
    end
    @(posedge clk);
    #1;
    m_rdv[d] = r_v && exp_r;
    if (m_rdv[d]) m_last[d] = rval;
  endtask

  task automatic wr(input int d, input logic [AW-1:0] a, input logic [W-1:0] data, input logic [NB-1:0] m);
    logic a1, a2, a3, a4;
    drive_cycle(d, 1'b1, a, data, m, 1'b0, '0, a1, a2, a3, a4);
  endtask

  task automatic rd(input int d, input logic [AW-1:0] a);
    logic a1, a2, a3, a4;
    drive_cycle(d, 1'b0, '0, '0, '0, 1'b1, a, a1, a2, a3, a4);
  endtask

  task automatic idle(input int d);
    logic a1, a2, a3, a4;
    drive_cycle(d, 1'b0, '0, '0, '0, 1'b0, '0, a1, a2, a3, a4);
  endtask

  task automatic fill_memory();
    logic [W-1:0] v;
    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < 256; a++) begin
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom();
        wr(d, AW'(a), v, '1);
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      t_wv[d] = 1'b1; t_wa[d] = '0; t_wd[d] = '0; t_wm[d] = '1;
      t_rv[d] = 1'b1; t_ra[d] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (o_wrdy[d] !== 1'b0 || o_rrdy[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_rdy d%0d: got wr=%b rd=%b want 0 0", d, o_wrdy[d], o_rrdy[d]);
      end
      checks++;
      if (o_rdv[d] !== 1'b0 || o_rdat[d] !== '0) begin
        errors++;
        $display("FAIL reset_out d%0d: got val=%b data=%h want 0 0", d, o_rdv[d], o_rdat[d]);
      end
    end
    apply_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (o_wrdy[d] !== 1'b1 || o_rrdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_rdy d%0d: got wr=%b rd=%b want 1 1", d, o_wrdy[d], o_rrdy[d]);
      end
      checks++;
      if (o_rdv[d] !== 1'b0 || o_rdat[d] !== '0) begin
        errors++;
        $display("FAIL post_reset_out d%0d: got val=%b data=%h want 0 0", d, o_rdv[d], o_rdat[d]);
      end
    end
  endtask

  task automatic test_basic();
    for (int d = 0; d < 3; d++) begin
      wr(d, 8'd5, pat_a5, '1);
      rd(d, 8'd5);
      checks++;
      if (o_rdv[d] !== 1'b1 || o_rdat[d] !== pat_a5) begin
        errors++;
        $display("FAIL basic_read d%0d: got val=%b data=%h want 1 %h", d, o_rdv[d], o_rdat[d], pat_a5);
      end
      for (int n = 0; n < 3; n++) begin
        idle(d);
        checks++;
        if (o_rdv[d] !== 1'b0 || o_rdat[d] !== pat_a5) begin
          errors++;
          $display("FAIL basic_hold d%0d c%0d: got val=%b data=%h want 0 %h", d, n, o_rdv[d], o_rdat[d], pat_a5);
        end
      end
    end
  endtask

  task automatic test_byte_mask();
    logic [W-1:0] exp;
    exp = pat_ones;
    exp[63:0] = '0;
    for (int d = 0; d < 3; d++) begin
      wr(d, 8'd9, pat_ones, '1);
      wr(d, 8'd9, '0, 32'h0000_00FF);
      rd(d, 8'd9);
      checks++;
      if (o_rdv[d] !== 1'b1 || o_rdat[d] !== exp) begin
        errors++;
        $display("FAIL byte_mask d%0d: got val=%b data=%h want 1 %h", d, o_rdv[d], o_rdat[d], exp);
      end
    end
  endtask

  task automatic test_conflict();
    logic gw, gr, ew, er;
    logic [W-1:0] v;
    for (int i = 0; i < 4; i++) begin
      v = {8{$urandom()}};
      drive_cycle(0, 1'b1, 8'd4, v, '1, 1'b1, 8'd8, gw, gr, ew, er);
      checks++;
      if (gw !== (i % 2 == 0) || gr !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL conflict_rdy c%0d: got wr=%b rd=%b want %b %b", i, gw, gr, (i % 2 == 0), (i % 2 == 1));
      end
      checks++;
      if (o_rdv[0] !== (i % 2 == 1) || o_rdat[0] !== m_last[0]) begin
        errors++;
        $display("FAIL conflict_data c%0d: got val=%b data=%h want %b %h", i, o_rdv[0], o_rdat[0], (i % 2 == 1), m_last[0]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      v = {8{$urandom()}};
      drive_cycle(0, 1'b1, 8'd4, v, '1, 1'b1, 8'd5, gw, gr, ew, er);
      checks++;
      if (gw !== 1'b1 || gr !== 1'b1) begin
        errors++;
        $display("FAIL diff_bank_rdy c%0d: got wr=%b rd=%b want 1 1", i, gw, gr);
      end
      checks++;
      if (o_rdv[0] !== 1'b1 || o_rdat[0] !== pat_a5) begin
        errors++;
        $display("FAIL diff_bank_data c%0d: got val=%b data=%h want 1 %h", i, o_rdv[0], o_rdat[0], pat_a5);
      end
    end
  endtask

  task automatic test_collision();
    logic gw, gr, ew, er;
    logic [W-1:0] merged, exp;
    merged = {pat_aa[255:128], pat_55[127:0]};
    for (int d = 1; d < 3; d++) begin
      wr(d, 8'd12, pat_aa, '1);
      drive_cycle(d, 1'b1, 8'd12, pat_55, 32'h0000_FFFF, 1'b1, 8'd12, gw, gr, ew, er);
      exp = (d == 1) ? pat_aa : merged;
      checks++;
      if (o_rdv[d] !== 1'b1 || o_rdat[d] !== exp) begin
        errors++;
        $display("FAIL collision d%0d: got val=%b data=%h want 1 %h", d, o_rdv[d], o_rdat[d], exp);
      end
      rd(d, 8'd12);
      checks++;
      if (o_rdat[d] !== merged) begin
        errors++;
        $display("FAIL collision_after d%0d: got %h want %h", d, o_rdat[d], merged);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic gw, gr, ew, er;
    // One conflict leaves the read side next in line.
    drive_cycle(0, 1'b1, 8'd4, pat_55, '1, 1'b1, 8'd8, gw, gr, ew, er);
    rd(0, 8'd5);
    rst = 1'b1;
    #1;
    checks++;
    if (o_rdv[0] !== 1'b0 || o_rdat[0] !== '0) begin
      errors++;
      $display("FAIL reset_mid_out: got val=%b data=%h want 0 0", o_rdv[0], o_rdat[0]);
    end
    apply_reset();
    drive_cycle(0, 1'b1, 8'd4, pat_aa, '1, 1'b1, 8'd8, gw, gr, ew, er);
    checks++;
    if (gw !== 1'b1 || gr !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_prio: got wr=%b rd=%b want 1 0", gw, gr);
    end
    rd(0, 8'd5);
    checks++;
    if (o_rdv[0] !== 1'b1 || o_rdat[0] !== pat_a5) begin
      errors++;
      $display("FAIL reset_mid_keep: got val=%b data=%h want 1 %h", o_rdv[0], o_rdat[0], pat_a5);
    end
  endtask

  task automatic test_stall();
    logic gw, gr, ew, er;
    logic [W-1:0] exp;
    int pulses;
    apply_reset();
    exp = m_mem[0][20];
    pulses = 0;
    drive_cycle(0, 1'b1, 8'd16, pat_55, '1, 1'b1, 8'd20, gw, gr, ew, er);
    checks++;
    if (gw !== 1'b1 || gr !== 1'b0) begin
      errors++;
      $display("FAIL stall_rdy: got wr=%b rd=%b want 1 0", gw, gr);
    end
    if (o_rdv[0] === 1'b1) pulses++;
    drive_cycle(0, 1'b0, '0, '0, '0, 1'b1, 8'd20, gw, gr, ew, er);
    checks++;
    if (gr !== 1'b1 || o_rdat[0] !== exp) begin
      errors++;
      $display("FAIL stall_read: got rd=%b data=%h want 1 %h", gr, o_rdat[0], exp);
    end
    if (o_rdv[0] === 1'b1) pulses++;
    for (int n = 0; n < 3; n++) begin
      idle(0);
      if (o_rdv[0] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL stall_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_random();
    logic          gw, gr, ew, er;
    logic          cw, cr, pend_w, pend_r;
    logic [AW-1:0] wa, ra;
    logic [W-1:0]  wd;
    logic [NB-1:0] wm;
    for (int d = 0; d < 3; d++) begin
      pend_w = 1'b0; pend_r = 1'b0;
      cw = 1'b0; cr = 1'b0; wa = '0; ra = '0; wd = '0; wm = '0;
      for (int n = 0; n < 300; n++) begin
        if (!pend_w) begin
          cw = 1'($urandom_range(0, 1));
          wa = AW'($urandom_range(0, 15));
          for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom();
          wm = $urandom();
        end
        if (!pend_r) begin
          cr = 1'($urandom_range(0, 1));
          ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15));
        end
        drive_cycle(d, cw, wa, wd, wm, cr, ra, gw, gr, ew, er);
        checks++;
        if (gw !== ew || gr !== er) begin
          errors++;
          $display("FAIL rand_rdy d%0d c%0d: got wr=%b rd=%b want %b %b", d, n, gw, gr, ew, er);
        end
        checks++;
        if (o_rdv[d] !== m_rdv[d] || o_rdat[d] !== m_last[d]) begin
          errors++;
          $display("FAIL rand_data d%0d c%0d: got val=%b data=%h want %b %h", d, n, o_rdv[d], o_rdat[d], m_rdv[d], m_last[d]);
        end
        pend_w = cw && !ew;
        pend_r = cr && !er;
      end
    end
  endtask

  initial begin
    pat_a5   = {32{8'hA5}};
    pat_aa   = {32{8'hAA}};
    pat_55   = {32{8'h55}};
    pat_ones = '1;
    for (int d = 0; d < 3; d++) begin
      t_wv[d] = 1'b0; t_wa[d] = '0; t_wd[d] = '0; t_wm[d] = '0;
      t_rv[d] = 1'b0; t_ra[d] = '0;
    end
    model_reset();
    test_reset();
    fill_memory();
    test_basic();
    test_byte_mask();
    test_conflict();
    test_collision();
    test_reset_mid();
    test_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
